// File: rtl/memory_game_pkg.sv
// Shared types for the memory-game engine: play modes and FSM states.
package memory_game_pkg;

  typedef enum logic [1:0] {
    MODE_CLASSIC = 2'd0,
    MODE_TIMED   = 2'd1,
    MODE_REVERSE = 2'd2
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_APPEND   = 3'd1,
    ST_SHOW_ON  = 3'd2,
    ST_SHOW_OFF = 3'd3,
    ST_INPUT    = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/memory_game_engine_pattern_store.sv
// Pattern register file: one synchronous write port, one asynchronous read port.
module pattern_store #(
  parameter int DEPTH  = 25,
  parameter int DATA_W = 3,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Write the addressed entry; contents survive reset on purpose.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (we && (waddr == ADDR_W'(i))) begin
        mem_r[i] <= wdata;
      end
    end
  end

  // Read mux over all entries; addresses past DEPTH read as zero.
  always_comb begin
    rdata = {DATA_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      rdata = (raddr == ADDR_W'(i)) ? mem_r[i] : rdata;
    end
  end

endmodule

// File: rtl/memory_game_engine.sv
// Memory-game engine: append a random symbol each round, play the pattern back,
// then check presses in classic, timed or reverse-recall order.
module memory_game_engine
  import memory_game_pkg::*;
#(
  parameter int  NUM_SYM     = 8,
  parameter int  MAX_LEN     = 25,
  parameter int  SHOW_CYC    = 4,
  parameter int  GAP_CYC     = 2,
  parameter int  TIMEOUT_CYC = 64,
  localparam int SYM_W       = $clog2(NUM_SYM),
  localparam int LEN_W       = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         mode,
  input  logic               start,
  input  logic [SYM_W-1:0]   rnd,
  input  logic               btn_valid,
  input  logic [SYM_W-1:0]   btn_sym,
  output logic               rnd_en,
  output logic [NUM_SYM-1:0] led,
  output logic               input_ready,
  output logic [LEN_W-1:0]   level,
  output logic [LEN_W-1:0]   score,
  output logic               game_over,
  output logic               win,
  output logic               timeout
);

  localparam int PH_W = $clog2(max_int(SHOW_CYC, GAP_CYC) + 1);
  localparam int TM_W = $clog2(TIMEOUT_CYC + 1);

  state_e           state_r, state_nxt_s;
  mode_e            mode_r, mode_nxt_s;
  logic [LEN_W-1:0] level_r, level_nxt_s;
  logic [LEN_W-1:0] score_r, score_nxt_s;
  logic [LEN_W-1:0] idx_r, idx_nxt_s;
  logic [LEN_W-1:0] pos_r, pos_nxt_s;
  logic [PH_W-1:0]  phase_r, phase_nxt_s;
  logic [TM_W-1:0]  timer_r, timer_nxt_s;
  logic             game_over_r, game_over_nxt_s;
  logic             win_r, win_nxt_s;
  logic             timeout_r, timeout_nxt_s;

  logic [SYM_W-1:0] sym_s;
  logic [SYM_W-1:0] rd_data_s;
  logic [LEN_W-1:0] exp_idx_s;
  logic [LEN_W-1:0] rd_addr_s;
  logic             hit_s;
  logic             last_pos_s;
  logic             wr_en_s;

  // LFSR values past the symbol range fold back by one NUM_SYM.
  assign sym_s = ({1'b0, rnd} < (SYM_W + 1)'(NUM_SYM)) ? rnd
               : SYM_W'({1'b0, rnd} - (SYM_W + 1)'(NUM_SYM));

  assign exp_idx_s  = (mode_r == MODE_REVERSE) ? (level_r - pos_r - LEN_W'(1)) : pos_r;
  assign rd_addr_s  = (state_r == ST_INPUT) ? exp_idx_s : idx_r;
  assign last_pos_s = (pos_r == level_r - LEN_W'(1));
  assign hit_s      = ({1'b0, btn_sym} < (SYM_W + 1)'(NUM_SYM)) && (btn_sym == rd_data_s);
  assign wr_en_s    = (state_r == ST_APPEND);

  pattern_store #(
    .DEPTH  (MAX_LEN),
    .DATA_W (SYM_W),
    .ADDR_W (LEN_W)
  ) u_store (
    .clk   (clk),
    .we    (wr_en_s),
    .waddr (level_r),
    .wdata (sym_s),
    .raddr (rd_addr_s),
    .rdata (rd_data_s)
  );

  assign rnd_en      = (state_r == ST_APPEND);
  assign input_ready = (state_r == ST_INPUT);
  assign led         = (state_r == ST_SHOW_ON) ? ({{(NUM_SYM - 1){1'b0}}, 1'b1} << rd_data_s)
                                               : {NUM_SYM{1'b0}};
  assign level       = level_r;
  assign score       = score_r;
  assign game_over   = game_over_r;
  assign win         = win_r;
  assign timeout     = timeout_r;

  // Next-state and datapath updates for every FSM-owned register.
  always_comb begin
    state_nxt_s     = state_r;
    mode_nxt_s      = mode_r;
    level_nxt_s     = level_r;
    score_nxt_s     = score_r;
    idx_nxt_s       = idx_r;
    pos_nxt_s       = pos_r;
    phase_nxt_s     = phase_r;
    timer_nxt_s     = timer_r;
    game_over_nxt_s = game_over_r;
    win_nxt_s       = win_r;
    timeout_nxt_s   = timeout_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          case (mode)
            2'd1:    mode_nxt_s = MODE_TIMED;
            2'd2:    mode_nxt_s = MODE_REVERSE;
            default: mode_nxt_s = MODE_CLASSIC;
          endcase
          level_nxt_s     = {LEN_W{1'b0}};
          score_nxt_s     = {LEN_W{1'b0}};
          game_over_nxt_s = 1'b0;
          win_nxt_s       = 1'b0;
          timeout_nxt_s   = 1'b0;
          state_nxt_s     = ST_APPEND;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_APPEND: begin
        level_nxt_s = level_r + LEN_W'(1);
        idx_nxt_s   = {LEN_W{1'b0}};
        phase_nxt_s = {PH_W{1'b0}};
        state_nxt_s = ST_SHOW_ON;
      end
      ST_SHOW_ON: begin
        if (phase_r == PH_W'(SHOW_CYC - 1)) begin
          phase_nxt_s = {PH_W{1'b0}};
          state_nxt_s = ST_SHOW_OFF;
        end else begin
          phase_nxt_s = phase_r + PH_W'(1);
        end
      end
      ST_SHOW_OFF: begin
        if (phase_r == PH_W'(GAP_CYC - 1)) begin
          phase_nxt_s = {PH_W{1'b0}};
          if (idx_r == level_r - LEN_W'(1)) begin
            pos_nxt_s   = {LEN_W{1'b0}};
            timer_nxt_s = {TM_W{1'b0}};
            state_nxt_s = ST_INPUT;
          end else begin
            idx_nxt_s   = idx_r + LEN_W'(1);
            state_nxt_s = ST_SHOW_ON;
          end
        end else begin
          phase_nxt_s = phase_r + PH_W'(1);
        end
      end
      ST_INPUT: begin
        // A press always takes priority over the timeout limit.
        if (btn_valid) begin
          if (!hit_s) begin
            game_over_nxt_s = 1'b1;
            state_nxt_s     = ST_DONE;
          end else if (!last_pos_s) begin
            pos_nxt_s   = pos_r + LEN_W'(1);
            timer_nxt_s = {TM_W{1'b0}};
          end else begin
            score_nxt_s = level_r;
            timer_nxt_s = {TM_W{1'b0}};
            if (level_r == LEN_W'(MAX_LEN)) begin
              win_nxt_s   = 1'b1;
              state_nxt_s = ST_DONE;
            end else begin
              state_nxt_s = ST_APPEND;
            end
          end
        end else if ((mode_r == MODE_TIMED) && (timer_r == TM_W'(TIMEOUT_CYC - 1))) begin
          game_over_nxt_s = 1'b1;
          timeout_nxt_s   = 1'b1;
          state_nxt_s     = ST_DONE;
        end else begin
          timer_nxt_s = timer_r + TM_W'(1);
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State and datapath registers; the pattern memory is deliberately not reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      mode_r      <= MODE_CLASSIC;
      level_r     <= {LEN_W{1'b0}};
      score_r     <= {LEN_W{1'b0}};
      idx_r       <= {LEN_W{1'b0}};
      pos_r       <= {LEN_W{1'b0}};
      phase_r     <= {PH_W{1'b0}};
      timer_r     <= {TM_W{1'b0}};
      game_over_r <= 1'b0;
      win_r       <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      mode_r      <= mode_nxt_s;
      level_r     <= level_nxt_s;
      score_r     <= score_nxt_s;
      idx_r       <= idx_nxt_s;
      pos_r       <= pos_nxt_s;
      phase_r     <= phase_nxt_s;
      timer_r     <= timer_nxt_s;
      game_over_r <= game_over_nxt_s;
      win_r       <= win_nxt_s;
      timeout_r   <= timeout_nxt_s;
    end
  end

endmodule

// File: tb/tb_memory_game_engine.sv
// Directed bench for memory_game_engine: an 8-symbol and a 5-symbol instance share stimulus.
module tb_memory_game_engine;

  logic       clk = 1'b0;
  logic       rst, start, btn_valid, use_b;
  logic [1:0] mode;
  logic [2:0] rnd, btn_sym;

  logic       rnd_en_a, ready_a, go_a, win_a, to_a;
  logic [7:0] led_a;
  logic [2:0] level_a, score_a;
  logic       rnd_en_b, ready_b, go_b, win_b, to_b;
  logic [4:0] led_b;
  logic [2:0] level_b, score_b;

  logic       ready_m, rnd_en_m;
  logic [7:0] led_m;

  int errors_n = 0;
  int checks_n = 0;
  int pat [4];

  always #5 clk = ~clk;

  memory_game_engine #(
    .NUM_SYM(8), .MAX_LEN(4), .SHOW_CYC(4), .GAP_CYC(2), .TIMEOUT_CYC(64)
  ) dut_a (
    .clk(clk), .rst(rst), .mode(mode), .start(start), .rnd(rnd),
    .btn_valid(btn_valid), .btn_sym(btn_sym), .rnd_en(rnd_en_a), .led(led_a),
    .input_ready(ready_a), .level(level_a), .score(score_a),
    .game_over(go_a), .win(win_a), .timeout(to_a)
  );

  memory_game_engine #(
    .NUM_SYM(5), .MAX_LEN(4), .SHOW_CYC(4), .GAP_CYC(2), .TIMEOUT_CYC(64)
  ) dut_b (
    .clk(clk), .rst(rst), .mode(mode), .start(start), .rnd(rnd),
    .btn_valid(btn_valid), .btn_sym(btn_sym), .rnd_en(rnd_en_b), .led(led_b),
    .input_ready(ready_b), .level(level_b), .score(score_b),
    .game_over(go_b), .win(win_b), .timeout(to_b)
  );

  assign ready_m  = use_b ? ready_b  : ready_a;
  assign rnd_en_m = use_b ? rnd_en_b : rnd_en_a;
  assign led_m    = use_b ? {3'b000, led_b} : led_a;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_n++;
    if (got !== exp) begin
      errors_n++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; btn_valid = 1'b0; btn_sym = 3'd0; rnd = 3'd0; mode = 2'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Leaves the bench observing the APPEND cycle.
  task automatic start_game(input logic [1:0] m);
    mode = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic press(input logic [2:0] s);
    btn_valid = 1'b1; btn_sym = s;
    @(negedge clk);
    btn_valid = 1'b0; btn_sym = 3'd0;
  endtask

  // From the APPEND cycle: playback of pat[0..len-1] (4 lit, 2 dark each), then INPUT.
  task automatic await_input(input string tag, input int len);
    int cyc, bad, pulses, k;
    logic [7:0] want;
    cyc = 0; bad = 0; pulses = 0;
    while (ready_m !== 1'b1 && cyc < 400) begin
      want = 8'h00;
      if (cyc > 0) begin
        k = cyc - 1;
        if ((k / 6) < len && (k % 6) < 4) want = 8'h01 << pat[k / 6];
      end
      if (led_m !== want) bad++;
      if (rnd_en_m === 1'b1) pulses++;
      @(negedge clk);
      cyc++;
    end
    check_eq({tag, "_cycles"}, cyc, 1 + 6 * len);
    check_eq({tag, "_led_errs"}, bad, 0);
    check_eq({tag, "_rnd_en_pulses"}, pulses, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    use_b = 1'b0;
    rst = 1'b1; start = 1'b0; btn_valid = 1'b0; btn_sym = 3'd0; rnd = 3'd0; mode = 2'd0;
    repeat (2) @(negedge clk);
    check_eq("rst_outs_a", {led_a, rnd_en_a, ready_a, level_a, score_a, go_a, win_a, to_a}, 0);
    check_eq("rst_outs_b", {led_b, rnd_en_b, ready_b, level_b, score_b, go_b, win_b, to_b}, 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_ready", ready_a, 0);

    // Classic game to a win with pattern 3,5,1,6.
    pat = '{3, 5, 1, 6};
    rnd = 3'd3;
    start_game(2'd0);
    for (int r = 1; r <= 4; r++) begin
      await_input($sformatf("classic_r%0d", r), r);
      check_eq($sformatf("classic_level_r%0d", r), level_a, r);
      for (int p = 0; p < r; p++) begin
        if (p == r - 1 && r < 4) rnd = 3'(pat[r]);
        press(3'(pat[p]));
      end
      check_eq($sformatf("classic_score_r%0d", r), score_a, r);
      check_eq($sformatf("classic_go_r%0d", r), go_a, 0);
      if (r < 4) check_eq($sformatf("classic_win_r%0d", r), win_a, 0);
    end
    check_eq("classic_win", win_a, 1);
    check_eq("classic_done_ready", ready_a, 0);
    repeat (3) @(negedge clk);
    check_eq("classic_hold", {win_a, go_a, score_a, level_a}, {1'b1, 1'b0, 3'd4, 3'd4});

    // Classic mismatch in round 2; also no timeout in classic mode.
    pat = '{3, 5, 0, 0};
    rnd = 3'd3;
    start_game(2'd0);
    check_eq("restart_clear", {win_a, go_a, score_a, level_a}, 0);
    await_input("mis_r1", 1);
    repeat (70) @(negedge clk);
    check_eq("classic_no_timeout", {ready_a, go_a}, 2'b10);
    rnd = 3'd5;
    press(3'd3);
    await_input("mis_r2", 2);
    press(3'd3);
    press(3'd2);
    check_eq("mis_flags", {go_a, win_a, to_a, ready_a}, 4'b1000);
    check_eq("mis_score", score_a, 1);

    // Reverse recall; mode input changes after start are ignored.
    rnd = 3'd3;
    start_game(2'd2);
    mode = 2'd0;
    await_input("rev_r1", 1);
    rnd = 3'd5;
    press(3'd3);
    await_input("rev_r2", 2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("rev_start_ignored", {ready_a, level_a}, {1'b1, 3'd2});
    press(3'd5);
    press(3'd3);
    check_eq("rev_score", {score_a, go_a}, {3'd2, 1'b0});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rnd = 3'd3;
    start_game(2'd2);
    await_input("rev2_r1", 1);
    rnd = 3'd5;
    press(3'd3);
    await_input("rev2_r2", 2);
    press(3'd3);
    check_eq("rev_forward_fail", {go_a, score_a}, {1'b1, 3'd1});

    // Timed: presses at the last allowed cycle win, silence times out.
    pat = '{3, 5, 1, 0};
    rnd = 3'd3;
    start_game(2'd1);
    await_input("tim_r1", 1);
    repeat (62) @(negedge clk);
    rnd = 3'd5;
    press(3'd3);
    check_eq("tim_score1", score_a, 1);
    await_input("tim_r2", 2);
    repeat (63) @(negedge clk);
    check_eq("tim_ready_c63", ready_a, 1);
    press(3'd3);
    check_eq("tim_press_c63", {ready_a, go_a}, 2'b10);
    repeat (63) @(negedge clk);
    rnd = 3'd1;
    press(3'd5);
    check_eq("tim_score2", {score_a, go_a}, {3'd2, 1'b0});
    await_input("tim_r3", 3);
    repeat (63) @(negedge clk);
    check_eq("tim_before_limit", {ready_a, go_a, to_a}, 3'b100);
    @(negedge clk);
    check_eq("tim_timeout", {ready_a, go_a, to_a, score_a}, {1'b0, 1'b1, 1'b1, 3'd2});

    // Five-symbol instance: rnd 6 folds to symbol 1, btn 7 is out of range.
    do_reset();
    use_b = 1'b1;
    pat = '{1, 0, 0, 0};
    rnd = 3'd6;
    start_game(2'd0);
    await_input("n5_r1", 1);
    check_eq("n5_level", level_b, 1);
    press(3'd7);
    check_eq("n5_bad_sym", {go_b, score_b, win_b}, {1'b1, 3'd0, 1'b0});
    use_b = 1'b0;

    // Reset during round-3 playback.
    do_reset();
    pat = '{3, 5, 1, 0};
    rnd = 3'd3;
    start_game(2'd0);
    await_input("rr_r1", 1);
    rnd = 3'd5;
    press(3'd3);
    await_input("rr_r2", 2);
    rnd = 3'd1;
    press(3'd3);
    press(3'd5);
    @(negedge clk);
    check_eq("rr_show_on", led_a, 8'h08);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rr_outs_zero", {led_a, rnd_en_a, ready_a, level_a, score_a, go_a, win_a, to_a}, 0);
    rst = 1'b0;
    pat = '{4, 0, 0, 0};
    rnd = 3'd4;
    start_game(2'd0);
    await_input("rr_new", 1);
    check_eq("rr_new_level", level_a, 1);

    $display("Result: errors=%0d of %0d checks", errors_n, checks_n);
    $finish;
  end

endmodule
